// File: rtl/proc_ring_pe.sv
// Systolic ring processing element: forwards samples and emits a signed dot product every N terms.
// Optional macro PROC_RING_SAT_EN saturates the final result to the signed DATA_W range.
module proc_ring_pe #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned N         = 4,
    parameter int unsigned OUT_SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init,
    input  logic [DATA_W-1:0]         x_init,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         x,
    input  logic                      a_load,
    input  logic [DATA_W-1:0]         a_in,
    output logic [DATA_W-1:0]         y,
    output logic                      y_valid,
    output logic                      y_is_sum,
    output logic [$clog2(N)-1:0]      cnt
);

    localparam int unsigned CNT_W  = $clog2(N);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic signed [DATA_W-1:0] a_reg;
    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  sum_c;
    logic        [DATA_W-1:0] res_c;

    // Signed MAC; the size cast of a signed product sign-extends into the accumulator width
    always_comb begin
        prod_c = $signed(x) * a_reg;
        sum_c  = acc + ACC_W'(prod_c);
    end

`ifdef PROC_RING_SAT_EN
    logic signed [ACC_W-1:0] shifted_c;

    // Clamp when the bits above the DATA_W sign bit are not a pure sign extension
    always_comb begin
        shifted_c = sum_c >>> OUT_SHIFT;
        res_c     = shifted_c[DATA_W-1:0];
        if (!((&shifted_c[ACC_W-1:DATA_W-1]) || !(|shifted_c[ACC_W-1:DATA_W-1]))) begin
            res_c = shifted_c[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        res_c = DATA_W'(sum_c >>> OUT_SHIFT);
    end
`endif

    // Coefficient register; a load takes effect from the next accepted sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg <= '0;
        end else if (a_load) begin
            a_reg <= $signed(a_in);
        end
    end

    // Forward/accumulate datapath with init taking priority over a valid sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y        <= '0;
            y_valid  <= 1'b0;
            y_is_sum <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
        end else if (init) begin
            y        <= x_init;
            y_valid  <= 1'b1;
            y_is_sum <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
        end else if (in_valid) begin
            y_valid <= 1'b1;
            if (cnt == LAST) begin
                y        <= res_c;
                y_is_sum <= 1'b1;
                cnt      <= '0;
                acc      <= '0;
            end else begin
                y        <= x;
                y_is_sum <= 1'b0;
                cnt      <= cnt + CNT_W'(1);
                acc      <= sum_c;
            end
        end else begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_proc_ring_pe.sv
// Directed bench for proc_ring_pe: vector table for steady-state behaviour plus hand-written reset sequences.
module tb_proc_ring_pe;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 2;

`ifdef PROC_RING_SAT_EN
    localparam logic [15:0] E5_POS = 16'h7FFF;
    localparam logic [15:0] E5_NEG = 16'h8000;
`else
    localparam logic [15:0] E5_POS = 16'h0004;
    localparam logic [15:0] E5_NEG = 16'h0000;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              init;
    logic [DATA_W-1:0] x_init;
    logic              in_valid;
    logic [DATA_W-1:0] x;
    logic              a_load;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] y;
    logic              y_valid;
    logic              y_is_sum;
    logic [CNT_W-1:0]  cnt;

    typedef struct {
        logic        init;
        logic [15:0] x_init;
        logic        in_valid;
        logic [15:0] x;
        logic        a_load;
        logic [15:0] a_in;
        logic [15:0] ey;
        logic        ev;
        logic        es;
        logic [1:0]  ec;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    proc_ring_pe #(.DATA_W(16), .ACC_W(40), .N(4), .OUT_SHIFT(0)) dut (
        .clk(clk), .reset(reset), .init(init), .x_init(x_init),
        .in_valid(in_valid), .x(x), .a_load(a_load), .a_in(a_in),
        .y(y), .y_valid(y_valid), .y_is_sum(y_is_sum), .cnt(cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic i, input logic [15:0] xi, input logic iv,
                                input logic [15:0] xv, input logic al, input logic [15:0] ai,
                                input logic [15:0] ey, input logic ev, input logic es,
                                input logic [1:0] ec);
        vec_t r;
        r.init = i; r.x_init = xi; r.in_valid = iv; r.x = xv; r.a_load = al; r.a_in = ai;
        r.ey = ey; r.ev = ev; r.es = es; r.ec = ec;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] ey, input logic ev,
                             input logic es, input logic [1:0] ec);
        chk({tag, ".y"}, y, ey);
        chk({tag, ".y_valid"}, 16'(y_valid), 16'(ev));
        chk({tag, ".y_is_sum"}, 16'(y_is_sum), 16'(es));
        chk({tag, ".cnt"}, 16'(cnt), 16'(ec));
    endtask

    task automatic idle_inputs();
        init = 1'b0; x_init = '0; in_valid = 1'b0; x = '0; a_load = 1'b0; a_in = '0;
    endtask

    // Drive one cycle of inputs at the falling edge; outputs are sampled at the next falling edge
    task automatic drive(input logic iv, input logic [15:0] xv, input logic al, input logic [15:0] ai);
        init = 1'b0; in_valid = iv; x = xv; a_load = al; a_in = ai;
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #12;
        check_all("reset", 16'h0000, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        reset = 1'b0;

        // init pulse
        vecs.push_back(mk(1, 16'h1234, 0, 0, 0, 0, 16'h1234, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h1234, 0, 0, 0));
        // a=3, back-to-back 1..4
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'd3, 16'h1234, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'd1, 0, 0, 16'd1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 16'd2, 0, 0, 16'd2, 1, 0, 2));
        vecs.push_back(mk(0, 0, 1, 16'd3, 0, 0, 16'd3, 1, 0, 3));
        vecs.push_back(mk(0, 0, 1, 16'd4, 0, 0, 16'h001E, 1, 1, 0));
        // same vector with idle gaps
        vecs.push_back(mk(0, 0, 1, 16'd1, 0, 0, 16'd1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 16'd7, 0, 0, 16'd1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 16'd2, 0, 0, 16'd2, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd2, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd2, 0, 0, 2));
        vecs.push_back(mk(0, 0, 1, 16'd3, 0, 0, 16'd3, 1, 0, 3));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd3, 0, 0, 3));
        vecs.push_back(mk(0, 0, 1, 16'd4, 0, 0, 16'h001E, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h001E, 0, 1, 0));
        // init mid-vector wins over in_valid and clears the partial sum
        vecs.push_back(mk(0, 0, 1, 16'd1, 0, 0, 16'd1, 1, 0, 1));
        vecs.push_back(mk(1, 16'h0055, 1, 16'd9, 0, 0, 16'h0055, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'd1, 0, 0, 16'd1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 16'd2, 0, 0, 16'd2, 1, 0, 2));
        vecs.push_back(mk(0, 0, 1, 16'd3, 0, 0, 16'd3, 1, 0, 3));
        vecs.push_back(mk(0, 0, 1, 16'd4, 0, 0, 16'h001E, 1, 1, 0));
        // negative coefficient
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'hFFFE, 16'h001E, 0, 1, 0));
        for (int i = 1; i <= 3; i++) vecs.push_back(mk(0, 0, 1, 16'd100, 0, 0, 16'd100, 1, 0, 2'(i)));
        vecs.push_back(mk(0, 0, 1, 16'd100, 0, 0, 16'hFCE0, 1, 1, 0));
        // positive overflow
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h7FFF, 16'hFCE0, 0, 1, 0));
        for (int i = 1; i <= 3; i++) vecs.push_back(mk(0, 0, 1, 16'h7FFF, 0, 0, 16'h7FFF, 1, 0, 2'(i)));
        vecs.push_back(mk(0, 0, 1, 16'h7FFF, 0, 0, E5_POS, 1, 1, 0));
        // negative overflow
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h8000, E5_POS, 0, 1, 0));
        for (int i = 1; i <= 3; i++) vecs.push_back(mk(0, 0, 1, 16'h7FFF, 0, 0, 16'h7FFF, 1, 0, 2'(i)));
        vecs.push_back(mk(0, 0, 1, 16'h7FFF, 0, 0, E5_NEG, 1, 1, 0));

        foreach (vecs[i]) begin
            init = vecs[i].init; x_init = vecs[i].x_init; in_valid = vecs[i].in_valid;
            x = vecs[i].x; a_load = vecs[i].a_load; a_in = vecs[i].a_in;
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].ey, vecs[i].ev, vecs[i].es, vecs[i].ec);
        end
        idle_inputs();

        // Asynchronous reset after two terms, observed before any clock edge
        drive(1'b0, 16'd0, 1'b1, 16'd3);
        drive(1'b1, 16'd1, 1'b0, 16'd0);
        drive(1'b1, 16'd2, 1'b0, 16'd0);
        chk("pre_reset.y_valid", 16'(y_valid), 16'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 16'h0000, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 16'd0, 1'b1, 16'd3);
        drive(1'b1, 16'd1, 1'b0, 16'd0);
        drive(1'b1, 16'd2, 1'b0, 16'd0);
        drive(1'b1, 16'd3, 1'b0, 16'd0);
        drive(1'b1, 16'd4, 1'b0, 16'd0);
        check_all("after_reset_sum", 16'h001E, 1'b1, 1'b1, 2'd0);

        // Coefficient load alongside term 2 only affects terms 3 and 4
        drive(1'b1, 16'd1, 1'b0, 16'd0);
        drive(1'b1, 16'd1, 1'b1, 16'd5);
        drive(1'b1, 16'd1, 1'b0, 16'd0);
        drive(1'b1, 16'd1, 1'b0, 16'd0);
        check_all("a_load_mid", 16'h0010, 1'b1, 1'b1, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
